sbox_share_sched: RTL and testbench

// - Shares one bank of LANES sbox instances between the AES-256 key expansion (SubWord, 32 bit) and the round datapath (SubBytes, 128 bit).
// - Arbitrates whole transactions between the two requesters and sequences each one over the lanes in beats.
// - Returns registered results with a one-cycle valid pulse. Sits between key_expand / round datapath and the sbox ROMs.

---
 rtl/aes_pkg.sv | 14 +
 rtl/sbox.sv | 29 ++
 rtl/sbox_lane_bank.sv | 16 +
 rtl/sbox_share_sched.sv | 142 ++++++++++++++
 tb/tb_sbox_share_sched.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES widths and the sbox scheduler state encoding.
package aes_pkg;

    localparam int unsigned AES_WORD_W  = 32;
    localparam int unsigned AES_STATE_W = 128;
    localparam int unsigned AES_BYTES   = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN_KS,
        RUN_DP
    } sched_state_t;

endpackage

// File: rtl/sbox.sv
// Single AES forward S-box as a combinational ROM.
module sbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    // Entry 0 sits in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign out_o = SBOX_TABLE[11'd2047 - {in_i, 3'b000} -: 8];

endmodule

// File: rtl/sbox_lane_bank.sv
// LANES parallel S-boxes; byte i of the input feeds lane i.
module sbox_lane_bank #(
    parameter int unsigned LANES = 4
) (
    input  logic [8*LANES-1:0] data_i,
    output logic [8*LANES-1:0] data_o
);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        sbox u_sbox (
            .in_i  (data_i[8*i +: 8]),
            .out_o (data_o[8*i +: 8])
        );
    end

endmodule

// File: rtl/sbox_share_sched.sv
// Time-shares one S-box lane bank between key expansion (SubWord) and the round
// datapath (SubBytes), arbitrating whole transactions and sequencing them in beats.
module sbox_share_sched
    import aes_pkg::*;
#(
    parameter int unsigned LANES       = 4,
    parameter bit          KS_PRIORITY = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ks_req,
    input  logic [AES_WORD_W-1:0]  ks_word,
    output logic                   ks_gnt,
    output logic                   ks_valid,
    output logic [AES_WORD_W-1:0]  ks_result,
    input  logic                   dp_req,
    input  logic [AES_STATE_W-1:0] dp_state,
    output logic                   dp_gnt,
    output logic                   dp_valid,
    output logic [AES_STATE_W-1:0] dp_result,
    output logic                   busy
);

    if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
        $error("sbox_share_sched: LANES must be 1, 2 or 4");
    end

    localparam int unsigned LANE_W = 8 * LANES;
    localparam int unsigned N_KS   = (AES_WORD_W / 8) / LANES;
    localparam int unsigned N_DP   = AES_BYTES / LANES;
    localparam int unsigned BEAT_W = 4;
    localparam logic [BEAT_W-1:0] LAST_KS = BEAT_W'(N_KS - 1);
    localparam logic [BEAT_W-1:0] LAST_DP = BEAT_W'(N_DP - 1);

    sched_state_t            state_q, state_d;
    logic [BEAT_W-1:0]       beat_q, beat_d;
    logic [AES_STATE_W-1:0]  op_q, op_d;
    logic [AES_STATE_W-1:0]  shadow_q, shadow_d;
    logic                    last_ks_q, last_ks_d;
    logic                    ks_valid_q, ks_valid_d;
    logic                    dp_valid_q, dp_valid_d;
    logic [AES_WORD_W-1:0]   ks_result_q, ks_result_d;
    logic [AES_STATE_W-1:0]  dp_result_q, dp_result_d;

    logic [LANE_W-1:0]       lane_in, lane_out;
    logic                    ks_win;
    logic                    last_beat;
    int unsigned             beat_base;

    sbox_lane_bank #(
        .LANES (LANES)
    ) u_lanes (
        .data_i (lane_in),
        .data_o (lane_out)
    );

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        op_d        = op_q;
        shadow_d    = shadow_q;
        last_ks_d   = last_ks_q;
        ks_valid_d  = 1'b0;
        dp_valid_d  = 1'b0;
        ks_result_d = ks_result_q;
        dp_result_d = dp_result_q;
        ks_gnt      = 1'b0;
        dp_gnt      = 1'b0;

        // Round-robin: on a tie, ks wins unless it also won the previous grant.
        ks_win    = ks_req && (!dp_req || KS_PRIORITY || !last_ks_q);
        beat_base = LANE_W * 32'(beat_q);
        lane_in   = op_q[beat_base +: LANE_W];
        last_beat = (state_q == RUN_KS && beat_q == LAST_KS) ||
                    (state_q == RUN_DP && beat_q == LAST_DP);

        unique case (state_q)
            IDLE: begin
                if (ks_req || dp_req) begin
                    ks_gnt    = ks_win && !rst;
                    dp_gnt    = !ks_win && !rst;
                    beat_d    = '0;
                    last_ks_d = ks_win;
                    if (ks_win) begin
                        state_d = RUN_KS;
                        op_d    = {{(AES_STATE_W - AES_WORD_W){1'b0}}, ks_word};
                    end else begin
                        state_d = RUN_DP;
                        op_d    = dp_state;
                    end
                end
            end
            RUN_KS, RUN_DP: begin
                shadow_d[beat_base +: LANE_W] = lane_out;
                beat_d = beat_q + 1'b1;
                if (last_beat) begin
                    state_d = IDLE;
                    beat_d  = '0;
                    if (state_q == RUN_KS) begin
                        ks_valid_d  = 1'b1;
                        ks_result_d = shadow_d[AES_WORD_W-1:0];
                    end else begin
                        dp_valid_d  = 1'b1;
                        dp_result_d = shadow_d;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            op_q        <= '0;
            shadow_q    <= '0;
            last_ks_q   <= 1'b0;
            ks_valid_q  <= 1'b0;
            dp_valid_q  <= 1'b0;
            ks_result_q <= '0;
            dp_result_q <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            op_q        <= op_d;
            shadow_q    <= shadow_d;
            last_ks_q   <= last_ks_d;
            ks_valid_q  <= ks_valid_d;
            dp_valid_q  <= dp_valid_d;
            ks_result_q <= ks_result_d;
            dp_result_q <= dp_result_d;
        end
    end

    assign ks_valid  = ks_valid_q;
    assign dp_valid  = dp_valid_q;
    assign ks_result = ks_result_q;
    assign dp_result = dp_result_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sbox_share_sched.sv
// Bench for sbox_share_sched: four builds (L4 RR, L4 ks-priority, L1, L2) checked
// against a GF(2^8) S-box model and a transaction-level arbitration/latency model.
module tb_sbox_share_sched;

    logic         clk;
    logic         rst;
    logic         ks_req    [4];
    logic [31:0]  ks_word   [4];
    logic         ks_gnt    [4];
    logic         ks_valid  [4];
    logic [31:0]  ks_result [4];
    logic         dp_req    [4];
    logic [127:0] dp_state  [4];
    logic         dp_gnt    [4];
    logic         dp_valid  [4];
    logic [127:0] dp_result [4];
    logic         busy      [4];

    int errors = 0;
    int checks = 0;
    bit model_last_ks [4];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int unsigned L = (g == 2) ? 1 : (g == 3) ? 2 : 4;
        localparam bit          P = (g == 1);
        sbox_share_sched #(
            .LANES       (L),
            .KS_PRIORITY (P)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .ks_req    (ks_req[g]),
            .ks_word   (ks_word[g]),
            .ks_gnt    (ks_gnt[g]),
            .ks_valid  (ks_valid[g]),
            .ks_result (ks_result[g]),
            .dp_req    (dp_req[g]),
            .dp_state  (dp_state[g]),
            .dp_gnt    (dp_gnt[g]),
            .dp_valid  (dp_valid[g]),
            .dp_result (dp_result[g]),
            .busy      (busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lanes_of(input int v);
        return (v == 2) ? 1 : (v == 3) ? 2 : 4;
    endfunction

    // S-box from first principles: multiplicative inverse then affine map.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_ref(input logic [7:0] a);
        logic [7:0] inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, a);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] ref_sub(input logic [127:0] x, input int nb);
        logic [127:0] r = '0;
        for (int i = 0; i < nb; i++) r[8*i +: 8] = sbox_ref(x[8*i +: 8]);
        return r;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input int v);
        for (int c = 0; c < 50; c++) begin
            #1;
            if (!busy[v]) break;
            @(negedge clk);
        end
        check("idle_timeout", busy[v], 1'b0);
    endtask

    // One transaction into an idle DUT; expected latency is 1 + beats.
    task automatic run_txn(input int v, input bit is_ks, input logic [127:0] op);
        int           nb  = is_ks ? 4 : 16;
        int           lat = 1 + nb / lanes_of(v);
        logic [127:0] exp_res = ref_sub(op, nb);
        logic [127:0] other_before;
        @(negedge clk);
        other_before = is_ks ? dp_result[v] : 128'(ks_result[v]);
        if (is_ks) begin
            ks_req[v]  = 1'b1;
            ks_word[v] = op[31:0];
        end else begin
            dp_req[v]   = 1'b1;
            dp_state[v] = op;
        end
        #1;
        check("gnt", is_ks ? ks_gnt[v] : dp_gnt[v], 1'b1);
        check("gnt_other", is_ks ? dp_gnt[v] : ks_gnt[v], 1'b0);
        check("busy_at_grant", busy[v], 1'b0);
        model_last_ks[v] = is_ks;
        for (int n = 1; n <= lat; n++) begin
            @(negedge clk);
            ks_req[v]   = 1'b0;
            dp_req[v]   = 1'b0;
            ks_word[v]  = $urandom;
            dp_state[v] = {$urandom, $urandom, $urandom, $urandom};
            #1;
            if (n < lat) begin
                check("busy_mid", busy[v], 1'b1);
                check("valid_early", is_ks ? ks_valid[v] : dp_valid[v], 1'b0);
            end else begin
                check("valid", is_ks ? ks_valid[v] : dp_valid[v], 1'b1);
                check("result", is_ks ? 128'(ks_result[v]) : dp_result[v], exp_res);
                check("busy_done", busy[v], 1'b0);
            end
            check("other_valid", is_ks ? dp_valid[v] : ks_valid[v], 1'b0);
        end
        @(negedge clk);
        #1;
        check("valid_pulse", is_ks ? ks_valid[v] : dp_valid[v], 1'b0);
        check("result_held", is_ks ? 128'(ks_result[v]) : dp_result[v], exp_res);
        check("other_result", is_ks ? dp_result[v] : 128'(ks_result[v]), other_before);
    endtask

    task automatic tie_test(input int v);
        int grants = 0;
        bit exp_ks;
        @(negedge clk);
        ks_req[v]   = 1'b1;
        dp_req[v]   = 1'b1;
        ks_word[v]  = $urandom;
        dp_state[v] = {$urandom, $urandom, $urandom, $urandom};
        for (int c = 0; c < 200 && grants < 4; c++) begin
            #1;
            if (ks_gnt[v] || dp_gnt[v]) begin
                check("tie_single", ks_gnt[v] && dp_gnt[v], 1'b0);
                exp_ks = (v == 1) ? 1'b1 : !model_last_ks[v];
                check("tie_winner", ks_gnt[v], exp_ks);
                model_last_ks[v] = exp_ks;
                grants++;
            end
            @(negedge clk);
        end
        check("tie_grants", grants, 4);
        ks_req[v] = 1'b0;
        dp_req[v] = 1'b0;
        wait_idle(v);
    endtask

    initial begin
        logic [127:0] op;
        logic [127:0] exp;
        logic [31:0]  kw;
        bit           seen;

        for (int v = 0; v < 4; v++) begin
            ks_req[v]   = 1'b0;
            dp_req[v]   = 1'b0;
            ks_word[v]  = '0;
            dp_state[v] = '0;
            model_last_ks[v] = 1'b0;
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Requests during reset must not be granted.
        ks_req[0] = 1'b1;
        dp_req[0] = 1'b1;
        #1;
        check("rst_ks_gnt", ks_gnt[0], 1'b0);
        check("rst_dp_gnt", dp_gnt[0], 1'b0);
        for (int v = 0; v < 4; v++) begin
            check("rst_busy", busy[v], 1'b0);
            check("rst_ks_valid", ks_valid[v], 1'b0);
            check("rst_dp_valid", dp_valid[v], 1'b0);
            check("rst_ks_result", ks_result[v], '0);
            check("rst_dp_result", dp_result[v], '0);
        end
        ks_req[0] = 1'b0;
        dp_req[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        run_txn(0, 1'b1, 128'h09cf4f3c);
        op = 128'h00112233445566778899aabbccddeeff;
        run_txn(0, 1'b0, op);
        check("dp_known_vector", dp_result[0], 128'h638293c31bfc33f5c4eeacea4bc12816);
        run_txn(2, 1'b0, op);
        run_txn(3, 1'b0, op);
        run_txn(2, 1'b1, 128'h09cf4f3c);
        run_txn(3, 1'b1, 128'hdeadbeef);

        for (int i = 0; i < 10; i++) begin
            op = {$urandom, $urandom, $urandom, $urandom};
            run_txn($urandom_range(0, 3), 1'($urandom_range(0, 1)), op);
        end

        tie_test(0);
        tie_test(1);

        // ks raised mid-dp must wait for the dp completion cycle.
        op  = {$urandom, $urandom, $urandom, $urandom};
        exp = ref_sub(op, 16);
        kw  = $urandom;
        @(negedge clk);
        dp_req[0]   = 1'b1;
        dp_state[0] = op;
        #1;
        check("mid_dp_gnt", dp_gnt[0], 1'b1);
        model_last_ks[0] = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            dp_req[0] = 1'b0;
            if (n == 2) begin
                ks_req[0]  = 1'b1;
                ks_word[0] = kw;
            end
            #1;
            if (n >= 2 && n < 5) check("mid_no_ks_gnt", ks_gnt[0], 1'b0);
        end
        check("mid_ks_gnt", ks_gnt[0], 1'b1);
        check("mid_dp_valid", dp_valid[0], 1'b1);
        check("mid_dp_result", dp_result[0], exp);
        model_last_ks[0] = 1'b1;
        exp = ref_sub(128'(kw), 4);
        @(negedge clk);
        ks_req[0] = 1'b0;
        #1;
        check("mid_ks_busy", busy[0], 1'b1);
        @(negedge clk);
        #1;
        check("mid_ks_valid", ks_valid[0], 1'b1);
        check("mid_ks_result", 128'(ks_result[0]), exp);

        // Reset in the middle of a dp transaction.
        @(negedge clk);
        dp_req[0]   = 1'b1;
        dp_state[0] = {$urandom, $urandom, $urandom, $urandom};
        #1;
        check("abort_dp_gnt", dp_gnt[0], 1'b1);
        @(negedge clk);
        dp_req[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst       = 1'b1;
        dp_req[0] = 1'b1;
        #1;
        check("abort_busy", busy[0], 1'b0);
        check("abort_dp_gnt_masked", dp_gnt[0], 1'b0);
        check("abort_dp_valid", dp_valid[0], 1'b0);
        check("abort_dp_result", dp_result[0], '0);
        check("abort_ks_result", ks_result[0], '0);
        check("abort_ks_valid", ks_valid[0], 1'b0);
        dp_req[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int v = 0; v < 4; v++) model_last_ks[v] = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            #1;
            if (dp_valid[0]) seen = 1'b1;
        end
        check("abort_no_valid", seen, 1'b0);
        run_txn(0, 1'b0, {$urandom, $urandom, $urandom, $urandom});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
